// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: serialises signed sample pairs MSB first with the
// standard one-BCLK word-select offset, with a one-entry holding register.
module i2s_tx #(
   parameter int unsigned WD   = 24,
   parameter int unsigned SLOT = 32,
   parameter int unsigned DIV  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [WD-1:0] l_data,
   input  logic [WD-1:0] r_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          bclk,
   output logic          lrclk,
   output logic          sdata,
   output logic          underrun
);

   localparam int unsigned DW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int unsigned FW = 2 * SLOT;
   localparam int unsigned BW = $clog2(FW);

   logic [DW-1:0]   div_cnt, div_nxt;
   logic [BW-1:0]   bit_cnt, bit_nxt;
   logic            hold_full, hold_nxt;
   logic [WD-1:0]   hold_l, hold_r;
   logic [FW-1:0]   frame, frame_nxt;
   logic [SLOT-1:0] l_slot, r_slot;
   logic            fall, frame_start, accept, und_nxt, lr_nxt;

   // Next-state: divider, bit position, frame shifter and holding register
   always_comb begin
      fall        = (div_cnt == DW'(DIV - 1));
      div_nxt     = fall ? '0 : div_cnt + DW'(1);
      bit_nxt     = bit_cnt;
      if (fall) begin
         bit_nxt = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + BW'(1);
      end
      frame_start = fall && (bit_nxt == '0);
      accept      = in_valid && in_ready;
      // Left-justify each sample in its slot; the tail of the slot is zero
      l_slot      = SLOT'(hold_l) << (SLOT - WD);
      r_slot      = SLOT'(hold_r) << (SLOT - WD);

      frame_nxt   = frame;
      hold_nxt    = hold_full;
      und_nxt     = 1'b0;
      if (fall) begin
         frame_nxt = frame << 1;
      end
      if (frame_start) begin
         frame_nxt = hold_full ? {l_slot, r_slot} : '0;
         und_nxt   = !hold_full;
         hold_nxt  = 1'b0;
      end
      if (accept) begin
         hold_nxt = 1'b1;
      end
      lr_nxt = (bit_nxt >= BW'(SLOT - 1)) && (bit_nxt <= BW'(FW - 2));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt   <= '0;
         bit_cnt   <= BW'(FW - 1);
         hold_full <= 1'b0;
         hold_l    <= '0;
         hold_r    <= '0;
         frame     <= '0;
         bclk      <= 1'b0;
         lrclk     <= 1'b0;
         sdata     <= 1'b0;
         underrun  <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         div_cnt   <= div_nxt;
         bit_cnt   <= bit_nxt;
         hold_full <= hold_nxt;
         frame     <= frame_nxt;
         if (accept) begin
            hold_l <= l_data;
            hold_r <= r_data;
         end
         bclk      <= (div_nxt >= DW'(DIV / 2));
         lrclk     <= lr_nxt;
         sdata     <= frame_nxt[FW-1];
         underrun  <= und_nxt;
         in_ready  <= !hold_nxt;
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: table of pairs with hand-computed serial
// frames, a scoreboard of expected frames and a cycle-level timing model.
module tb_i2s_tx;

   localparam int unsigned WD   = 24;
   localparam int unsigned SLOT = 32;
   localparam int unsigned DIV  = 4;
   localparam int unsigned FR   = DIV * 2 * SLOT;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [WD-1:0] l_data = '0;
   logic [WD-1:0] r_data = '0;
   logic          in_ready, bclk, lrclk, sdata, underrun;

   i2s_tx #(.WD(WD), .SLOT(SLOT), .DIV(DIV)) dut (
      .clk(clk), .reset(reset), .l_data(l_data), .r_data(r_data),
      .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk),
      .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WD-1:0]     l;
      logic [WD-1:0]     r;
      logic [2*SLOT-1:0] word;
   } vec_t;

   vec_t tbl[6];
   int   checks = 0;
   int   errors = 0;

   logic [2*SLOT-1:0] sb[$];
   logic [2*SLOT-1:0] cur_exp, got;
   int unsigned c, b, gc;
   bit   fall_m, frame_ok, armed, exp_und, acc_at_start;
   logic [3:0] exp_ctl;
   int   acc_n = 0;
   int   acc_cyc[$];
   int   cur_idx = 0;
   int   und_seen;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: advances on the same edge as the DUT, inputs are stable here
   always @(posedge clk) begin
      bit empty, acc;
      gc++;
      acc_at_start = 1'b0;
      if (reset) begin
         c = 0; b = 2*SLOT-1; sb.delete(); frame_ok = 1'b0;
         fall_m = 1'b0; exp_und = 1'b0; armed = 1'b1;
         exp_ctl = 4'b0001;
      end else begin
         empty   = (sb.size() == 0);
         acc     = in_valid && empty;
         c++;
         fall_m  = ((c % DIV) == 0);
         exp_und = 1'b0;
         if (fall_m) begin
            b = (b + 1) % (2*SLOT);
            if (b == 0) begin
               frame_ok = 1'b1;
               if (!empty) cur_exp = sb.pop_front();
               else begin cur_exp = '0; exp_und = 1'b1; end
            end
         end
         if (acc) begin
            sb.push_back(tbl[cur_idx].word);
            acc_n++;
            acc_cyc.push_back(int'(gc));
            acc_at_start = fall_m && (b == 0);
         end
         exp_ctl = {((c % DIV) >= DIV/2), (b >= SLOT-1 && b <= 2*SLOT-2), exp_und, (sb.size() == 0)};
      end
   end

   // Compare away from the active edge; rebuild each frame from sdata
   always @(negedge clk) begin
      if (armed) begin
         check("ctl{bclk,lrclk,underrun,in_ready}", 64'({bclk, lrclk, underrun, in_ready}), 64'(exp_ctl));
         if (reset) check("sdata_in_reset", 64'(sdata), 64'(0));
         else if (fall_m && frame_ok) begin
            got[2*SLOT-1-b] = sdata;
            if (b == 2*SLOT-1) check("frame_word", got, cur_exp);
         end
      end
   end

   task automatic wait_acc(input int n);
      int k;
      for (k = 0; k < 2*FR; k++) begin
         @(posedge clk); #1;
         if (acc_n >= n) break;
      end
      if (k == 2*FR) check("accept_timeout", 64'(acc_n), 64'(n));
   endtask

   task automatic wait_c_mod(input int unsigned m);
      int k;
      for (k = 0; k < 2*FR; k++) begin
         @(posedge clk); #1;
         if ((c % FR) == m) break;
      end
      if (k == 2*FR) check("align_timeout", 64'(c % FR), 64'(m));
   endtask

   initial begin
      tbl[0] = '{24'h800001, 24'h7FFFFF, 64'h80000100_7FFFFF00};
      tbl[1] = '{24'h000000, 24'hFFFFFF, 64'h00000000_FFFFFF00};
      tbl[2] = '{24'hA5A5A5, 24'h123456, 64'hA5A5A500_12345600};
      tbl[3] = '{24'h000001, 24'h800000, 64'h00000100_80000000};
      tbl[4] = '{24'hFFFFFF, 24'h000001, 64'hFFFFFF00_00000100};
      tbl[5] = '{24'h5A5A5A, 24'hC3C3C3, 64'h5A5A5A00_C3C3C300};

      // Reset held with in_valid high must not accept anything
      reset = 1'b1; in_valid = 1'b1; l_data = tbl[5].l; r_data = tbl[5].r;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; in_valid = 1'b0;
      #4 check("after_reset{bclk,lrclk,sdata,underrun,in_ready}",
               64'({bclk, lrclk, sdata, underrun, in_ready}), 64'(5'b00001));

      // Back-pressure: valid held high, a new pair offered after each accept
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cur_idx = i; l_data = tbl[i].l; r_data = tbl[i].r;
         wait_acc(i + 1);
      end
      in_valid = 1'b0;
      check("accept_gap_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(FR));
      check("accept_gap_3", 64'(acc_cyc[3] - acc_cyc[2]), 64'(FR));

      // Idle: drain, then exactly one underrun pulse per frame
      repeat (FR + 300) @(posedge clk);
      und_seen = 0;
      for (int k = 0; k < 3*FR; k++) begin
         @(posedge clk); #1;
         if (underrun) und_seen++;
      end
      check("underrun_pulses_3_frames", 64'(und_seen), 64'(3));

      // Accept landing on the frame-start clock with the hold register empty
      wait_c_mod(3);
      cur_idx = 4; l_data = tbl[4].l; r_data = tbl[4].r; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("same_cycle_accept_at_start", 64'(acc_at_start), 64'(1));
      check("same_cycle_underrun", 64'(underrun), 64'(1));
      check("same_cycle_held_ready", 64'(in_ready), 64'(0));
      repeat (2*FR + 8) @(posedge clk);

      // Reset mid-frame with a pair held: held pair is discarded
      wait_c_mod(DIV*3);
      cur_idx = 5; l_data = tbl[5].l; r_data = tbl[5].r; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_pair_held", 64'(in_ready), 64'(0));
      wait_c_mod(DIV*11);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_reset{bclk,lrclk,sdata,underrun,in_ready}",
            64'({bclk, lrclk, sdata, underrun, in_ready}), 64'(5'b00001));
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (DIV) @(posedge clk);
      #1 check("post_reset_underrun", 64'(underrun), 64'(1));
      repeat (FR + 8) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
